// File: rtl/axi_demux_1xn.sv
// AXI4 1-to-N address-decoded demultiplexer. Each direction carries at most one transaction
// at a time; unmapped addresses are terminated locally with DECERR.
module axi_demux_1xn #(
  parameter int M_COUNT    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter logic [M_COUNT*ADDR_WIDTH-1:0] M_BASE_ADDR = '0,
  parameter logic [M_COUNT*32-1:0]         M_ADDR_WIDTH = {M_COUNT{32'd24}},
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ID_WIDTH-1:0]              s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]            s_axi_awaddr,
  input  logic [7:0]                       s_axi_awlen,
  input  logic [2:0]                       s_axi_awsize,
  input  logic [1:0]                       s_axi_awburst,
  input  logic [2:0]                       s_axi_awprot,
  input  logic                             s_axi_awvalid,
  output logic                             s_axi_awready,
  input  logic [DATA_WIDTH-1:0]            s_axi_wdata,
  input  logic [STRB_WIDTH-1:0]            s_axi_wstrb,
  input  logic                             s_axi_wlast,
  input  logic                             s_axi_wvalid,
  output logic                             s_axi_wready,
  output logic [ID_WIDTH-1:0]              s_axi_bid,
  output logic [1:0]                       s_axi_bresp,
  output logic                             s_axi_bvalid,
  input  logic                             s_axi_bready,
  input  logic [ID_WIDTH-1:0]              s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]            s_axi_araddr,
  input  logic [7:0]                       s_axi_arlen,
  input  logic [2:0]                       s_axi_arsize,
  input  logic [1:0]                       s_axi_arburst,
  input  logic [2:0]                       s_axi_arprot,
  input  logic                             s_axi_arvalid,
  output logic                             s_axi_arready,
  output logic [ID_WIDTH-1:0]              s_axi_rid,
  output logic [DATA_WIDTH-1:0]            s_axi_rdata,
  output logic [1:0]                       s_axi_rresp,
  output logic                             s_axi_rlast,
  output logic                             s_axi_rvalid,
  input  logic                             s_axi_rready,
  output logic [M_COUNT*ID_WIDTH-1:0]      m_axi_awid,
  output logic [M_COUNT*ADDR_WIDTH-1:0]    m_axi_awaddr,
  output logic [M_COUNT*8-1:0]             m_axi_awlen,
  output logic [M_COUNT*3-1:0]             m_axi_awsize,
  output logic [M_COUNT*2-1:0]             m_axi_awburst,
  output logic [M_COUNT*3-1:0]             m_axi_awprot,
  output logic [M_COUNT-1:0]               m_axi_awvalid,
  input  logic [M_COUNT-1:0]               m_axi_awready,
  output logic [M_COUNT*DATA_WIDTH-1:0]    m_axi_wdata,
  output logic [M_COUNT*STRB_WIDTH-1:0]    m_axi_wstrb,
  output logic [M_COUNT-1:0]               m_axi_wlast,
  output logic [M_COUNT-1:0]               m_axi_wvalid,
  input  logic [M_COUNT-1:0]               m_axi_wready,
  input  logic [M_COUNT*ID_WIDTH-1:0]      m_axi_bid,
  input  logic [M_COUNT*2-1:0]             m_axi_bresp,
  input  logic [M_COUNT-1:0]               m_axi_bvalid,
  output logic [M_COUNT-1:0]               m_axi_bready,
  output logic [M_COUNT*ID_WIDTH-1:0]      m_axi_arid,
  output logic [M_COUNT*ADDR_WIDTH-1:0]    m_axi_araddr,
  output logic [M_COUNT*8-1:0]             m_axi_arlen,
  output logic [M_COUNT*3-1:0]             m_axi_arsize,
  output logic [M_COUNT*2-1:0]             m_axi_arburst,
  output logic [M_COUNT*3-1:0]             m_axi_arprot,
  output logic [M_COUNT-1:0]               m_axi_arvalid,
  input  logic [M_COUNT-1:0]               m_axi_arready,
  input  logic [M_COUNT*ID_WIDTH-1:0]      m_axi_rid,
  input  logic [M_COUNT*DATA_WIDTH-1:0]    m_axi_rdata,
  input  logic [M_COUNT*2-1:0]             m_axi_rresp,
  input  logic [M_COUNT-1:0]               m_axi_rlast,
  input  logic [M_COUNT-1:0]               m_axi_rvalid,
  output logic [M_COUNT-1:0]               m_axi_rready,
  output logic [15:0]                      decerr_count
);

  localparam int SelW = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_ADDR = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;
  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  // Returns {decerr, sel}; iterating downwards lets the lowest matching index win.
  function automatic logic [SelW:0] decode(input logic [ADDR_WIDTH-1:0] addr);
    logic [SelW-1:0]       sel;
    logic                  hit;
    logic [31:0]           aw;
    logic [ADDR_WIDTH-1:0] base;
    sel = '0;
    hit = 1'b0;
    for (int i = M_COUNT - 1; i >= 0; i--) begin
      aw   = M_ADDR_WIDTH[i*32 +: 32];
      base = M_BASE_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
      if (aw != 32'd0 && (addr >> aw) == (base >> aw)) begin
        hit = 1'b1;
        sel = SelW'(i);
      end
    end
    return {~hit, sel};
  endfunction

  logic [1:0]            w_state_q, w_state_d, r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   awid_q, awid_d, arid_q, arid_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [7:0]            awlen_q, awlen_d, arlen_q, arlen_d, beat_q, beat_d;
  logic [2:0]            awsize_q, awsize_d, arsize_q, arsize_d;
  logic [1:0]            awburst_q, awburst_d, arburst_q, arburst_d;
  logic [2:0]            awprot_q, awprot_d, arprot_q, arprot_d;
  logic [SelW-1:0]       wsel_q, wsel_d, rsel_q, rsel_d;
  logic                  wdecerr_q, wdecerr_d, rdecerr_q, rdecerr_d;
  logic [15:0]           decerr_count_q, decerr_count_d;
  logic [SelW:0]         aw_dec, ar_dec;
  logic                  aw_hs, ar_hs, aw_sel_ready, ar_sel_ready;
  logic [16:0]           cnt_sum;

  assign aw_dec        = decode(s_axi_awaddr);
  assign ar_dec        = decode(s_axi_araddr);
  assign s_axi_awready = (w_state_q == W_IDLE) && !rst;
  assign s_axi_arready = (r_state_q == R_IDLE) && !rst;
  assign aw_hs         = s_axi_awvalid && s_axi_awready;
  assign ar_hs         = s_axi_arvalid && s_axi_arready;
  assign decerr_count  = decerr_count_q;

  assign m_axi_awid    = {M_COUNT{awid_q}};
  assign m_axi_awaddr  = {M_COUNT{awaddr_q}};
  assign m_axi_awlen   = {M_COUNT{awlen_q}};
  assign m_axi_awsize  = {M_COUNT{awsize_q}};
  assign m_axi_awburst = {M_COUNT{awburst_q}};
  assign m_axi_awprot  = {M_COUNT{awprot_q}};
  assign m_axi_wdata   = {M_COUNT{s_axi_wdata}};
  assign m_axi_wstrb   = {M_COUNT{s_axi_wstrb}};
  assign m_axi_wlast   = {M_COUNT{s_axi_wlast}};
  assign m_axi_arid    = {M_COUNT{arid_q}};
  assign m_axi_araddr  = {M_COUNT{araddr_q}};
  assign m_axi_arlen   = {M_COUNT{arlen_q}};
  assign m_axi_arsize  = {M_COUNT{arsize_q}};
  assign m_axi_arburst = {M_COUNT{arburst_q}};
  assign m_axi_arprot  = {M_COUNT{arprot_q}};

  always_comb begin
    m_axi_awvalid = '0;
    m_axi_wvalid  = '0;
    m_axi_bready  = '0;
    aw_sel_ready  = 1'b0;
    s_axi_wready  = (w_state_q == W_DATA) && wdecerr_q;
    s_axi_bvalid  = (w_state_q == W_RESP) && wdecerr_q;
    s_axi_bid     = awid_q;
    s_axi_bresp   = 2'b11;
    for (int i = 0; i < M_COUNT; i++) begin
      if (SelW'(i) == wsel_q) begin
        aw_sel_ready     = m_axi_awready[i];
        m_axi_awvalid[i] = (w_state_q == W_ADDR);
        if (!wdecerr_q && w_state_q == W_DATA) begin
          m_axi_wvalid[i] = s_axi_wvalid;
          s_axi_wready    = m_axi_wready[i];
        end
        if (!wdecerr_q && w_state_q == W_RESP) begin
          m_axi_bready[i] = s_axi_bready;
          s_axi_bvalid    = m_axi_bvalid[i];
          s_axi_bid       = m_axi_bid[i*ID_WIDTH +: ID_WIDTH];
          s_axi_bresp     = m_axi_bresp[i*2 +: 2];
        end
      end
    end
  end

  always_comb begin
    m_axi_arvalid = '0;
    m_axi_rready  = '0;
    ar_sel_ready  = 1'b0;
    s_axi_rvalid  = (r_state_q == R_DATA) && rdecerr_q;
    s_axi_rid     = arid_q;
    s_axi_rdata   = '0;
    s_axi_rresp   = 2'b11;
    s_axi_rlast   = (beat_q == arlen_q);
    for (int i = 0; i < M_COUNT; i++) begin
      if (SelW'(i) == rsel_q) begin
        ar_sel_ready     = m_axi_arready[i];
        m_axi_arvalid[i] = (r_state_q == R_ADDR);
        if (!rdecerr_q && r_state_q == R_DATA) begin
          m_axi_rready[i] = s_axi_rready;
          s_axi_rvalid    = m_axi_rvalid[i];
          s_axi_rid       = m_axi_rid[i*ID_WIDTH +: ID_WIDTH];
          s_axi_rdata     = m_axi_rdata[i*DATA_WIDTH +: DATA_WIDTH];
          s_axi_rresp     = m_axi_rresp[i*2 +: 2];
          s_axi_rlast     = m_axi_rlast[i];
        end
      end
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    awid_d    = awid_q;
    awaddr_d  = awaddr_q;
    awlen_d   = awlen_q;
    awsize_d  = awsize_q;
    awburst_d = awburst_q;
    awprot_d  = awprot_q;
    wsel_d    = wsel_q;
    wdecerr_d = wdecerr_q;
    unique case (w_state_q)
      W_IDLE: if (aw_hs) begin
        awid_d    = s_axi_awid;
        awaddr_d  = s_axi_awaddr;
        awlen_d   = s_axi_awlen;
        awsize_d  = s_axi_awsize;
        awburst_d = s_axi_awburst;
        awprot_d  = s_axi_awprot;
        wsel_d    = aw_dec[SelW-1:0];
        wdecerr_d = aw_dec[SelW];
        w_state_d = aw_dec[SelW] ? W_DATA : W_ADDR;
      end
      W_ADDR: if (aw_sel_ready) w_state_d = W_DATA;
      W_DATA: if (s_axi_wvalid && s_axi_wready && s_axi_wlast) w_state_d = W_RESP;
      W_RESP: if (s_axi_bvalid && s_axi_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    arid_d    = arid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    arprot_d  = arprot_q;
    rsel_d    = rsel_q;
    rdecerr_d = rdecerr_q;
    beat_d    = beat_q;
    unique case (r_state_q)
      R_IDLE: if (ar_hs) begin
        arid_d    = s_axi_arid;
        araddr_d  = s_axi_araddr;
        arlen_d   = s_axi_arlen;
        arsize_d  = s_axi_arsize;
        arburst_d = s_axi_arburst;
        arprot_d  = s_axi_arprot;
        rsel_d    = ar_dec[SelW-1:0];
        rdecerr_d = ar_dec[SelW];
        beat_d    = 8'd0;
        r_state_d = ar_dec[SelW] ? R_DATA : R_ADDR;
      end
      R_ADDR: if (ar_sel_ready) r_state_d = R_DATA;
      R_DATA: if (s_axi_rvalid && s_axi_rready) begin
        beat_d = beat_q + 8'd1;
        if (s_axi_rlast) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Both directions can decode-fail in the same cycle, so the increment can be 2.
  always_comb begin
    cnt_sum = {1'b0, decerr_count_q} + 17'(aw_hs && aw_dec[SelW]) + 17'(ar_hs && ar_dec[SelW]);
    decerr_count_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q      <= W_IDLE;
      r_state_q      <= R_IDLE;
      awid_q         <= '0;
      awaddr_q       <= '0;
      awlen_q        <= '0;
      awsize_q       <= '0;
      awburst_q      <= '0;
      awprot_q       <= '0;
      wsel_q         <= '0;
      wdecerr_q      <= 1'b0;
      arid_q         <= '0;
      araddr_q       <= '0;
      arlen_q        <= '0;
      arsize_q       <= '0;
      arburst_q      <= '0;
      arprot_q       <= '0;
      rsel_q         <= '0;
      rdecerr_q      <= 1'b0;
      beat_q         <= '0;
      decerr_count_q <= '0;
    end else begin
      w_state_q      <= w_state_d;
      r_state_q      <= r_state_d;
      awid_q         <= awid_d;
      awaddr_q       <= awaddr_d;
      awlen_q        <= awlen_d;
      awsize_q       <= awsize_d;
      awburst_q      <= awburst_d;
      awprot_q       <= awprot_d;
      wsel_q         <= wsel_d;
      wdecerr_q      <= wdecerr_d;
      arid_q         <= arid_d;
      araddr_q       <= araddr_d;
      arlen_q        <= arlen_d;
      arsize_q       <= arsize_d;
      arburst_q      <= arburst_d;
      arprot_q       <= arprot_d;
      rsel_q         <= rsel_d;
      rdecerr_q      <= rdecerr_d;
      beat_q         <= beat_d;
      decerr_count_q <= decerr_count_d;
    end
  end

endmodule

// File: tb/tb_axi_demux_1xn.sv
// Directed bench for axi_demux_1xn: two ports at 0x0 and 0x0100_0000 (16 MiB each).
module tb_axi_demux_1xn;
  localparam int M  = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int IW = 8;
  localparam int SW = DW / 8;

  logic clk, rst;
  logic [IW-1:0] s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
  logic [AW-1:0] s_axi_awaddr, s_axi_araddr;
  logic [7:0]    s_axi_awlen, s_axi_arlen;
  logic [2:0]    s_axi_awsize, s_axi_arsize, s_axi_awprot, s_axi_arprot;
  logic [1:0]    s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic          s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic          s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic          s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [DW-1:0] s_axi_wdata, s_axi_rdata;
  logic [SW-1:0] s_axi_wstrb;

  logic [M*IW-1:0] m_axi_awid, m_axi_bid, m_axi_arid, m_axi_rid;
  logic [M*AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [M*8-1:0]  m_axi_awlen, m_axi_arlen;
  logic [M*3-1:0]  m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
  logic [M*2-1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic [M-1:0]    m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [M-1:0]    m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic [M-1:0]    m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [M*DW-1:0] m_axi_wdata, m_axi_rdata;
  logic [M*SW-1:0] m_axi_wstrb;
  logic [15:0]     decerr_count;

  int checks = 0;
  int errors = 0;

  axi_demux_1xn #(
    .M_COUNT     (M),
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .ID_WIDTH    (IW),
    .M_BASE_ADDR ({32'h0100_0000, 32'h0000_0000}),
    .M_ADDR_WIDTH({32'd24, 32'd24})
  ) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .decerr_count(decerr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = 3'd2;
    s_axi_awburst = 2'd1; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = 3'd2;
    s_axi_arburst = 2'd1; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    m_axi_awready = '0; m_axi_wready = '0; m_axi_bid = '0; m_axi_bresp = '0;
    m_axi_bvalid = '0; m_axi_arready = '0; m_axi_rid = '0; m_axi_rdata = '0;
    m_axi_rresp = '0; m_axi_rlast = '0; m_axi_rvalid = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_awready", s_axi_awready, 1'b0);
    chk("rst_arready", s_axi_arready, 1'b0);
    chk("rst_bvalid", s_axi_bvalid, 1'b0);
    chk("rst_rvalid", s_axi_rvalid, 1'b0);
    chk("rst_wready", s_axi_wready, 1'b0);
    chk("rst_m_awvalid", m_axi_awvalid, 2'b00);
    chk("rst_decerr", decerr_count, 16'h0);
    rst = 1'b0;
    #1;
    chk("rel_awready", s_axi_awready, 1'b1);
    chk("rel_arready", s_axi_arready, 1'b1);

    // Write to port 1 with W presented 3 cycles ahead of AW
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'hA5A5_0001; s_axi_wlast = 1'b0;
    m_axi_wready = 2'b11;
    #1;
    chk("early_w_wready", s_axi_wready, 1'b0);
    chk("early_w_m_wvalid", m_axi_wvalid, 2'b00);
    repeat (3) @(negedge clk);
    chk("early_w_wready3", s_axi_wready, 1'b0);
    s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h0100_0010; s_axi_awid = 8'h3C; s_axi_awlen = 8'd1;
    #1;
    chk("w1_awready", s_axi_awready, 1'b1);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    #1;
    chk("w1_m_awvalid", m_axi_awvalid, 2'b10);
    chk("w1_m_awaddr1", m_axi_awaddr[63:32], 32'h0100_0010);
    chk("w1_m_awaddr0", m_axi_awaddr[31:0], 32'h0100_0010);
    chk("w1_m_awid1", m_axi_awid[15:8], 8'h3C);
    chk("w1_awready_busy", s_axi_awready, 1'b0);
    chk("w1_wready_addr", s_axi_wready, 1'b0);
    m_axi_awready = 2'b10;
    @(negedge clk);
    m_axi_awready = 2'b00;
    #1;
    chk("w1_m_awvalid_off", m_axi_awvalid, 2'b00);
    chk("w1_m_wvalid_b1", m_axi_wvalid, 2'b10);
    chk("w1_wready_b1", s_axi_wready, 1'b1);
    chk("w1_m_wdata_b1", m_axi_wdata[63:32], 32'hA5A5_0001);
    chk("w1_m_wlast_b1", m_axi_wlast, 2'b00);
    @(negedge clk);
    s_axi_wdata = 32'hA5A5_0002; s_axi_wlast = 1'b1;
    #1;
    chk("w1_m_wvalid_b2", m_axi_wvalid, 2'b10);
    chk("w1_m_wdata_b2", m_axi_wdata, {32'hA5A5_0002, 32'hA5A5_0002});
    chk("w1_m_wlast_b2", m_axi_wlast, 2'b11);
    @(negedge clk);
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    s_axi_bready = 1'b1; m_axi_bvalid = 2'b10; m_axi_bid = 16'h3C00; m_axi_bresp = 4'b0100;
    #1;
    chk("w1_wready_resp", s_axi_wready, 1'b0);
    chk("w1_bvalid", s_axi_bvalid, 1'b1);
    chk("w1_bid", s_axi_bid, 8'h3C);
    chk("w1_bresp", s_axi_bresp, 2'b01);
    chk("w1_m_bready", m_axi_bready, 2'b10);
    @(negedge clk);
    m_axi_bvalid = 2'b00;
    #1;
    chk("w1_done_awready", s_axi_awready, 1'b1);
    chk("w1_done_bvalid", s_axi_bvalid, 1'b0);

    // DECERR read: 4 locally generated beats
    s_axi_arvalid = 1'b1; s_axi_araddr = 32'h0200_0000; s_axi_arlen = 8'd3; s_axi_arid = 8'd5;
    #1;
    chk("r1_arready", s_axi_arready, 1'b1);
    @(negedge clk);
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    #1;
    chk("r1_m_arvalid", m_axi_arvalid, 2'b00);
    chk("r1_decerr", decerr_count, 16'd1);
    chk("r1_rvalid", s_axi_rvalid, 1'b1);
    chk("r1_rresp", s_axi_rresp, 2'b11);
    chk("r1_rdata", s_axi_rdata, 32'h0);
    chk("r1_rid", s_axi_rid, 8'd5);
    chk("r1_m_rready", m_axi_rready, 2'b00);
    @(negedge clk);
    chk("r1_stall_rlast", s_axi_rlast, 1'b0);
    s_axi_rready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      #1;
      chk("r1_beat_rvalid", s_axi_rvalid, 1'b1);
      chk("r1_beat_rlast", s_axi_rlast, (b == 3));
      @(negedge clk);
    end
    #1;
    chk("r1_done_rvalid", s_axi_rvalid, 1'b0);
    chk("r1_done_arready", s_axi_arready, 1'b1);

    // Concurrent write to port 0 and read from port 1, plus a queued second AW
    @(negedge clk);
    s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h0000_1000; s_axi_awid = 8'h07; s_axi_awlen = 8'd0;
    s_axi_arvalid = 1'b1; s_axi_araddr = 32'h0100_0040; s_axi_arid = 8'h09; s_axi_arlen = 8'd0;
    m_axi_awready = 2'b11; m_axi_arready = 2'b11;
    @(negedge clk);
    s_axi_awaddr = 32'h0200_0000; s_axi_awid = 8'h44;
    s_axi_arvalid = 1'b0;
    #1;
    chk("c_m_awvalid", m_axi_awvalid, 2'b01);
    chk("c_m_arvalid", m_axi_arvalid, 2'b10);
    chk("c_awready_busy", s_axi_awready, 1'b0);
    @(negedge clk);
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'h1234_5678; s_axi_wlast = 1'b1;
    m_axi_rvalid = 2'b10; m_axi_rdata = {32'hDEAD_BEEF, 32'h0}; m_axi_rid = 16'h0900;
    m_axi_rlast = 2'b10; m_axi_rresp = 4'b0000; s_axi_rready = 1'b1;
    #1;
    chk("c_m_wvalid", m_axi_wvalid, 2'b01);
    chk("c_wready", s_axi_wready, 1'b1);
    chk("c_rvalid", s_axi_rvalid, 1'b1);
    chk("c_rdata", s_axi_rdata, 32'hDEAD_BEEF);
    chk("c_rid", s_axi_rid, 8'h09);
    chk("c_rresp", s_axi_rresp, 2'b00);
    chk("c_rlast", s_axi_rlast, 1'b1);
    chk("c_m_rready", m_axi_rready, 2'b10);
    @(negedge clk);
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; m_axi_rvalid = 2'b00;
    m_axi_bvalid = 2'b01; m_axi_bid = 16'h0007; m_axi_bresp = 4'b0000;
    #1;
    chk("c_arready_free", s_axi_arready, 1'b1);
    chk("c_awready_resp", s_axi_awready, 1'b0);
    chk("c_bvalid", s_axi_bvalid, 1'b1);
    chk("c_bid", s_axi_bid, 8'h07);
    chk("c_m_bready", m_axi_bready, 2'b01);
    @(negedge clk);
    m_axi_bvalid = 2'b00;
    #1;
    chk("c_awready_after_b", s_axi_awready, 1'b1);
    chk("c_decerr_hold", decerr_count, 16'd1);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    s_axi_wvalid = 1'b1; s_axi_wlast = 1'b1; s_axi_wdata = 32'hFFFF_0000;
    #1;
    chk("wd_decerr", decerr_count, 16'd2);
    chk("wd_wready", s_axi_wready, 1'b1);
    chk("wd_m_wvalid", m_axi_wvalid, 2'b00);
    @(negedge clk);
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    #1;
    chk("wd_bvalid", s_axi_bvalid, 1'b1);
    chk("wd_bresp", s_axi_bresp, 2'b11);
    chk("wd_bid", s_axi_bid, 8'h44);
    chk("wd_m_bready", m_axi_bready, 2'b00);
    @(negedge clk);
    #1;
    chk("wd_done_bvalid", s_axi_bvalid, 1'b0);

    // Reset in the middle of a 4-beat read from port 0
    s_axi_arvalid = 1'b1; s_axi_araddr = 32'h0000_0020; s_axi_arid = 8'h01; s_axi_arlen = 8'd3;
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    @(negedge clk);
    m_axi_rvalid = 2'b01; m_axi_rlast = 2'b00; m_axi_rdata = {32'h0, 32'h0000_0B01};
    m_axi_rid = 16'h0001;
    #1;
    chk("rr_b1_rvalid", s_axi_rvalid, 1'b1);
    chk("rr_b1_rdata", s_axi_rdata, 32'h0000_0B01);
    @(negedge clk);
    m_axi_rdata = {32'h0, 32'h0000_0B02};
    #1;
    chk("rr_b2_rdata", s_axi_rdata, 32'h0000_0B02);
    rst = 1'b1;
    #1;
    chk("rr_rvalid", s_axi_rvalid, 1'b0);
    chk("rr_m_rready", m_axi_rready, 2'b00);
    chk("rr_arready", s_axi_arready, 1'b0);
    chk("rr_decerr", decerr_count, 16'd0);
    @(negedge clk);
    rst = 1'b0; m_axi_rvalid = 2'b00;
    #1;
    chk("rr_rel_arready", s_axi_arready, 1'b1);
    chk("rr_rel_awready", s_axi_awready, 1'b1);

    // Simultaneous DECERR AW and AR
    s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h0200_0000; s_axi_awid = 8'hAA; s_axi_awlen = 8'd0;
    s_axi_arvalid = 1'b1; s_axi_araddr = 32'h0300_0000; s_axi_arid = 8'hBB; s_axi_arlen = 8'd0;
    @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
    #1;
    chk("dd_decerr2", decerr_count, 16'd2);
    chk("dd_rid", s_axi_rid, 8'hBB);
    chk("dd_rlast", s_axi_rlast, 1'b1);
    s_axi_wvalid = 1'b1; s_axi_wlast = 1'b1;
    @(negedge clk);
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    @(negedge clk);

    // Saturation: preload near the top, then overflow with a double increment
    force dut.decerr_count_q = 16'hFFFE;
    #1;
    release dut.decerr_count_q;
    s_axi_awvalid = 1'b1; s_axi_arvalid = 1'b1;
    @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
    #1;
    chk("sat_double", decerr_count, 16'hFFFF);
    s_axi_wvalid = 1'b1; s_axi_wlast = 1'b1;
    @(negedge clk);
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    @(negedge clk);
    s_axi_arvalid = 1'b1;
    #1;
    chk("sat_arready", s_axi_arready, 1'b1);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    #1;
    chk("sat_hold", decerr_count, 16'hFFFF);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
